// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the hazard/forwarding scoreboard.
// Scoreboard entries carry register indices at the RV32I width of 5 bits.
package hazard_scoreboard_pkg;

    localparam int SB_RD_W = 5;
    localparam int FWD_W   = 3;

    typedef logic [FWD_W-1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REGFILE = 3'd0;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               reg_wr;
        logic               is_load;
    } sb_entry_t;

    // Register x0 is hardwired to zero, so it never produces a forwarding hit.
    function automatic logic sb_hit(input sb_entry_t e, input logic [SB_RD_W-1:0] src);
        return e.valid && e.reg_wr && (e.rd == src) && (src != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sat_counter.sv
// Saturating up-counter with synchronous clear, used for performance statistics.
module hazard_scoreboard_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;

    // Count register: clears on reset, holds at all-ones once reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller: tracks in-flight destinations in a shift-register
// scoreboard and produces forwarding selects, load-use stalls and redirect flushes.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W       = 5,
    parameter int DEPTH            = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int FLUSH_CYCLES     = 1,
    parameter int CNT_W            = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_wr,
    input  logic                  id_is_load,
    input  logic                  redirect,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_flush,
    output logic                  stall,
    output fwd_sel_t              fwd_sel_rs1,
    output fwd_sel_t              fwd_sel_rs2,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      retire_cnt
);

    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

    sb_entry_t          sb_r [DEPTH];
    logic [1:0]         flush_left_r;
    logic [SB_RD_W-1:0] rs1_s, rs2_s;
    fwd_sel_t           sel1_s, sel2_s;
    logic               lu1_s, lu2_s;
    logic               flush_s, stall_s, load_s;
    sb_entry_t          new_entry_s;

    assign rs1_s = SB_RD_W'(id_rs1);
    assign rs2_s = SB_RD_W'(id_rs2);

    // Youngest-match search: scan oldest to youngest so the lowest stage overwrites.
    always_comb begin
        sel1_s = FWD_REGFILE;
        sel2_s = FWD_REGFILE;
        lu1_s  = 1'b0;
        lu2_s  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            sel1_s = (id_uses_rs1 && sb_hit(sb_r[k], rs1_s)) ? fwd_sel_t'(k + 1) : sel1_s;
            lu1_s  = (id_uses_rs1 && sb_hit(sb_r[k], rs1_s)) ?
                     (sb_r[k].is_load && ((k + 1) < LOAD_READY_STAGE)) : lu1_s;
            sel2_s = (id_uses_rs2 && sb_hit(sb_r[k], rs2_s)) ? fwd_sel_t'(k + 1) : sel2_s;
            lu2_s  = (id_uses_rs2 && sb_hit(sb_r[k], rs2_s)) ?
                     (sb_r[k].is_load && ((k + 1) < LOAD_READY_STAGE)) : lu2_s;
        end
    end

    // A flush discards the decode instruction anyway, so it overrides any load-use stall.
    assign flush_s = redirect || (flush_left_r != 2'd0);
    assign stall_s = id_valid && !flush_s && (lu1_s || lu2_s);
    assign load_s  = id_valid && !stall_s && !flush_s;

    assign new_entry_s = '{valid: 1'b1, rd: SB_RD_W'(id_rd), reg_wr: id_reg_wr, is_load: id_is_load};

    assign ifid_flush  = !reset && flush_s;
    assign stall       = !reset && stall_s;
    assign pc_en       = !stall;
    assign ifid_en     = !stall;
    assign fwd_sel_rs1 = (reset || !id_valid) ? FWD_REGFILE : sel1_s;
    assign fwd_sel_rs2 = (reset || !id_valid) ? FWD_REGFILE : sel2_s;

    // Scoreboard shift and redirect flush down-counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_r[k] <= '0;
            end
            flush_left_r <= 2'd0;
        end else begin
            sb_r[0] <= load_s ? new_entry_s : '0;
            for (int k = 1; k < DEPTH; k++) begin
                sb_r[k] <= sb_r[k-1];
            end
            flush_left_r <= redirect ? FLUSH_RELOAD :
                            ((flush_left_r != 2'd0) ? (flush_left_r - 2'd1) : 2'd0);
        end
    end

    hazard_scoreboard_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk(clk), .reset(reset), .inc(1'b1), .count(cycle_cnt)
    );

    hazard_scoreboard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .reset(reset), .inc(stall_s), .count(stall_cnt)
    );

    hazard_scoreboard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk(clk), .reset(reset), .inc(redirect), .count(flush_cnt)
    );

    hazard_scoreboard_sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk(clk), .reset(reset), .inc(sb_r[DEPTH-1].valid), .count(retire_cnt)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the in-flight instructions.
module tb_hazard_scoreboard;

    localparam int DEPTH = 2;
    localparam int LRS   = 2;
    localparam int FC    = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             id_valid = 1'b0;
    logic [4:0]       id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
    logic             id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic             id_reg_wr = 1'b0, id_is_load = 1'b0, redirect = 1'b0;
    logic             pc_en, ifid_en, ifid_flush, stall;
    logic [2:0]       fwd_sel_rs1, fwd_sel_rs2;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt, retire_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_scoreboard #(
        .REG_ADDR_W(5), .DEPTH(DEPTH), .LOAD_READY_STAGE(LRS),
        .FLUSH_CYCLES(FC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_is_load(id_is_load),
        .redirect(redirect), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .stall(stall),
        .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: queue index 0 is the youngest in-flight instruction (stage 1).
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
    } ment_t;

    ment_t mq[$];
    int    m_flush_left = 0;
    int    m_cyc = 0, m_stl = 0, m_fl = 0, m_ret = 0;

    function automatic int m_sel(int s, bit uses);
        if (reset || !id_valid || !uses || s == 0) return 0;
        foreach (mq[k]) begin
            if (mq[k].v && mq[k].wr && mq[k].rd == s) return k + 1;
        end
        return 0;
    endfunction

    function automatic bit m_flushing();
        return redirect || (m_flush_left > 0);
    endfunction

    function automatic bit m_stall();
        int  s1, s2;
        bit  l1, l2;
        if (reset || !id_valid || m_flushing()) return 0;
        s1 = m_sel(int'(id_rs1), id_uses_rs1);
        s2 = m_sel(int'(id_rs2), id_uses_rs2);
        l1 = (s1 > 0) && mq[s1-1].ld && (s1 < LRS);
        l2 = (s2 > 0) && mq[s2-1].ld && (s2 < LRS);
        return l1 || l2;
    endfunction

    function automatic int sat(int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    // Advance one clock edge and update the model with what the edge should do.
    task automatic tick();
        bit    st, fl;
        ment_t e;
        st = m_stall();
        fl = m_flushing();
        @(posedge clk);
        if (reset) begin
            mq.delete();
            e = '{v: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
            for (int k = 0; k < DEPTH; k++) mq.push_back(e);
            m_flush_left = 0;
            m_cyc = 0; m_stl = 0; m_fl = 0; m_ret = 0;
        end else begin
            m_cyc = sat(m_cyc + 1);
            m_stl = sat(m_stl + int'(st));
            m_fl  = sat(m_fl + int'(redirect));
            m_ret = sat(m_ret + int'(mq[DEPTH-1].v));
            m_flush_left = redirect ? FC - 1 : ((m_flush_left > 0) ? m_flush_left - 1 : 0);
            e = '{v: id_valid && !st && !fl, rd: int'(id_rd), wr: id_reg_wr, ld: id_is_load};
            mq.push_front(e);
            void'(mq.pop_back());
        end
        #1;
    endtask

    task automatic set_in(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit wr, bit ld, bit rdr);
        id_valid = v; id_rs1 = 5'(rs1); id_uses_rs1 = u1; id_rs2 = 5'(rs2); id_uses_rs2 = u2;
        id_rd = 5'(rd); id_reg_wr = wr; id_is_load = ld; redirect = rdr;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(1, 3, 1, 3, 1, 3, 1, 1, 1);
        tick();
        tick();
        n_tests++;
        if ({pc_en, ifid_en, ifid_flush, stall} !== 4'b1100) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 1100", {pc_en, ifid_en, ifid_flush, stall});
        end
        n_tests++;
        if ({fwd_sel_rs1, fwd_sel_rs2} !== 6'd0) begin
            n_fail++; $display("FAIL reset_fwd: got %0d/%0d expected 0/0", fwd_sel_rs1, fwd_sel_rs2);
        end
        n_tests++;
        if ({cycle_cnt, stall_cnt, flush_cnt, retire_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d %0d %0d %0d expected zeros", cycle_cnt, stall_cnt, flush_cnt, retire_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_forwarding();
        do_reset();
        set_in(1, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        set_in(1, 5, 1, 0, 0, 6, 1, 0, 0);
        #1;
        n_tests++;
        if (fwd_sel_rs1 !== 3'd1 || stall !== 1'b0) begin
            n_fail++; $display("FAIL fwd_stage1: got sel=%0d stall=%0d expected sel=1 stall=0", fwd_sel_rs1, stall);
        end
        tick();
        set_in(1, 0, 0, 5, 1, 8, 1, 0, 0);
        #1;
        n_tests++;
        if (fwd_sel_rs2 !== 3'd2) begin
            n_fail++; $display("FAIL fwd_stage2: got %0d expected 2", fwd_sel_rs2);
        end
        tick();
        set_in(1, 5, 1, 5, 1, 9, 1, 0, 0);
        #1;
        n_tests++;
        if ({fwd_sel_rs1, fwd_sel_rs2} !== 6'd0) begin
            n_fail++; $display("FAIL fwd_retired: got %0d/%0d expected 0/0", fwd_sel_rs1, fwd_sel_rs2);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(1, 0, 0, 0, 0, 7, 1, 1, 0);
        tick();
        set_in(1, 0, 0, 7, 1, 10, 1, 0, 0);
        #1;
        n_tests++;
        if ({stall, pc_en, ifid_en} !== 3'b100) begin
            n_fail++; $display("FAIL load_use_stall: got %b expected 100", {stall, pc_en, ifid_en});
        end
        tick();
        #1;
        n_tests++;
        if (stall !== 1'b0 || fwd_sel_rs2 !== 3'd2 || pc_en !== 1'b1) begin
            n_fail++; $display("FAIL load_use_release: got stall=%0d sel=%0d pc_en=%0d expected 0 2 1", stall, fwd_sel_rs2, pc_en);
        end
        tick();
        n_tests++;
        if (stall_cnt !== 4'd1 || cycle_cnt !== 4'd3) begin
            n_fail++; $display("FAIL load_use_cnt: got stall_cnt=%0d cycle_cnt=%0d expected 1 3", stall_cnt, cycle_cnt);
        end
    endtask

    task automatic test_x0_nowrite();
        do_reset();
        set_in(1, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        set_in(1, 0, 1, 0, 1, 9, 0, 0, 0);
        #1;
        n_tests++;
        if ({fwd_sel_rs1, fwd_sel_rs2} !== 6'd0) begin
            n_fail++; $display("FAIL x0_fwd: got %0d/%0d expected 0/0", fwd_sel_rs1, fwd_sel_rs2);
        end
        tick();
        set_in(1, 9, 1, 9, 1, 12, 1, 0, 0);
        #1;
        n_tests++;
        if ({fwd_sel_rs1, fwd_sel_rs2} !== 6'd0) begin
            n_fail++; $display("FAIL nowrite_fwd: got %0d/%0d expected 0/0", fwd_sel_rs1, fwd_sel_rs2);
        end
        tick();
    endtask

    task automatic test_redirect();
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        n_tests++;
        if (ifid_flush !== 1'b1 || pc_en !== 1'b1) begin
            n_fail++; $display("FAIL redirect_c1: got flush=%0d pc_en=%0d expected 1 1", ifid_flush, pc_en);
        end
        tick();
        redirect = 1'b0;
        #1;
        n_tests++;
        if (ifid_flush !== 1'b1) begin
            n_fail++; $display("FAIL redirect_c2: got %0d expected 1", ifid_flush);
        end
        tick();
        n_tests++;
        if (ifid_flush !== 1'b0 || flush_cnt !== 4'd1) begin
            n_fail++; $display("FAIL redirect_end: got flush=%0d flush_cnt=%0d expected 0 1", ifid_flush, flush_cnt);
        end
        do_reset();
        redirect = 1'b1;
        tick();
        #1;
        tick();
        redirect = 1'b0;
        #1;
        n_tests++;
        if (ifid_flush !== 1'b1) begin
            n_fail++; $display("FAIL redirect_ext_c3: got %0d expected 1", ifid_flush);
        end
        tick();
        n_tests++;
        if (ifid_flush !== 1'b0 || flush_cnt !== 4'd2) begin
            n_fail++; $display("FAIL redirect_ext_end: got flush=%0d flush_cnt=%0d expected 0 2", ifid_flush, flush_cnt);
        end
    endtask

    task automatic test_stall_redirect();
        do_reset();
        set_in(1, 0, 0, 0, 0, 7, 1, 1, 0);
        tick();
        set_in(1, 7, 1, 0, 0, 10, 1, 0, 1);
        #1;
        n_tests++;
        if ({stall, pc_en, ifid_en, ifid_flush} !== 4'b0111) begin
            n_fail++; $display("FAIL stall_vs_redirect: got %b expected 0111", {stall, pc_en, ifid_en, ifid_flush});
        end
        tick();
        set_in(1, 10, 1, 7, 1, 11, 1, 0, 0);
        #1;
        n_tests++;
        if (fwd_sel_rs1 !== 3'd0 || fwd_sel_rs2 !== 3'd2) begin
            n_fail++; $display("FAIL bubble_entered: got %0d/%0d expected 0/2", fwd_sel_rs1, fwd_sel_rs2);
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        n_tests++;
        if (retire_cnt !== 4'd1) begin
            n_fail++; $display("FAIL bubble_retire: got %0d expected 1", retire_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) tick();
        n_tests++;
        if (cycle_cnt !== 4'd15) begin
            n_fail++; $display("FAIL cycle_saturate: got %0d expected 15", cycle_cnt);
        end
        set_in(1, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        reset = 1'b1;
        set_in(1, 5, 1, 5, 1, 6, 1, 1, 1);
        #1;
        n_tests++;
        if ({pc_en, ifid_en, ifid_flush, stall, fwd_sel_rs1} !== 7'b1100000) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected 1100000", {pc_en, ifid_en, ifid_flush, stall, fwd_sel_rs1});
        end
        tick();
        reset = 1'b0;
        set_in(1, 5, 1, 5, 1, 6, 1, 0, 0);
        #1;
        n_tests++;
        if ({cycle_cnt, stall_cnt, flush_cnt, retire_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_clears_cnt: got %0d %0d %0d %0d expected zeros", cycle_cnt, stall_cnt, flush_cnt, retire_cnt);
        end
        n_tests++;
        if ({fwd_sel_rs1, fwd_sel_rs2, ifid_flush} !== 7'd0) begin
            n_fail++; $display("FAIL reset_clears_sb: got sel=%0d/%0d flush=%0d expected 0/0 0", fwd_sel_rs1, fwd_sel_rs2, ifid_flush);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 15) == 0);
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
            #1;
            n_tests++;
            if (fwd_sel_rs1 !== 3'(m_sel(int'(id_rs1), id_uses_rs1)) ||
                fwd_sel_rs2 !== 3'(m_sel(int'(id_rs2), id_uses_rs2))) begin
                n_fail++; $display("FAIL rand_fwd[%0d]: got %0d/%0d expected %0d/%0d", i, fwd_sel_rs1, fwd_sel_rs2,
                                   m_sel(int'(id_rs1), id_uses_rs1), m_sel(int'(id_rs2), id_uses_rs2));
            end
            n_tests++;
            if (stall !== m_stall() || pc_en !== !m_stall() || ifid_en !== !m_stall() ||
                ifid_flush !== (!reset && m_flushing())) begin
                n_fail++; $display("FAIL rand_ctrl[%0d]: got stall=%0d pc=%0d en=%0d flush=%0d expected stall=%0d flush=%0d",
                                   i, stall, pc_en, ifid_en, ifid_flush, m_stall(), !reset && m_flushing());
            end
            n_tests++;
            if (cycle_cnt !== 4'(m_cyc) || stall_cnt !== 4'(m_stl) ||
                flush_cnt !== 4'(m_fl) || retire_cnt !== 4'(m_ret)) begin
                n_fail++; $display("FAIL rand_cnt[%0d]: got %0d %0d %0d %0d expected %0d %0d %0d %0d", i,
                                   cycle_cnt, stall_cnt, flush_cnt, retire_cnt, m_cyc, m_stl, m_fl, m_ret);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_x0_nowrite();
        test_redirect();
        test_stall_redirect();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
